// File: rtl/nios_mem_if_ddr2_emif_0_p0_flop_mem_reader_if.sv
// Bus bundle for the flop-memory read sequencer: command channel,
// memory read port and output word stream.
//
// Handshake semantics (command and stream channels): a transfer happens in
// every cycle where valid and ready are both high at the rising clock edge.
// Once valid is raised, the sender holds it and the payload stable until the
// transfer; ready may be raised or lowered freely and never waits on valid.
// The memory read port is not a handshake: mem_rd_data is meaningful only in
// the cycle after mem_rd_en.
interface nios_mem_if_ddr2_emif_0_p0_flop_mem_reader_if #(
    parameter int READ_ADDR_WIDTH = 4,
    parameter int READ_DATA_WIDTH = 32,
    parameter int LEN_WIDTH       = 5
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [READ_ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]       cmd_len;

    logic                       mem_rd_en;
    logic [READ_ADDR_WIDTH-1:0] mem_rd_addr;
    logic [READ_DATA_WIDTH-1:0] mem_rd_data;

    logic                       out_valid;
    logic                       out_ready;
    logic [READ_DATA_WIDTH-1:0] out_data;
    logic                       out_last;

    // Reader side: consumes commands and memory data, produces the stream.
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, mem_rd_data, out_ready,
        output cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
    );

    // Environment side: command source, memory and stream sink.
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, mem_rd_data, out_ready,
        input  cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/nios_mem_if_ddr2_emif_0_p0_flop_mem_reader.sv
// Read-side burst sequencer for the flop-based memory. Turns a
// (start address, word count) command into one memory read per word, soaks
// up the one-cycle registered read latency with a 2-entry FIFO and presents
// the words as a valid/ready stream with a last-word marker.
module nios_mem_if_ddr2_emif_0_p0_flop_mem_reader #(
    parameter int READ_MEM_DEPTH  = 16,
    parameter int READ_ADDR_WIDTH = 4,
    parameter int READ_DATA_WIDTH = 32,
    parameter int LEN_WIDTH       = 5
) (
    input  logic        clk,
    input  logic        reset,
    nios_mem_if_ddr2_emif_0_p0_flop_mem_reader_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [READ_ADDR_WIDTH:0]   DEPTH_EXT = (READ_ADDR_WIDTH+1)'(READ_MEM_DEPTH);
    localparam logic [READ_ADDR_WIDTH-1:0] LAST_ADDR = READ_ADDR_WIDTH'(READ_MEM_DEPTH - 1);

    state_t                     state_q, state_d;
    logic [READ_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]       remaining_q, remaining_d;
    logic                       inflight_q;
    logic                       inflight_last_q;
    logic                       done_q;
    logic                       err_q;
    logic                       drain_done;

    logic [READ_DATA_WIDTH-1:0] fifo_data [2];
    logic                       fifo_last [2];
    logic                       rd_ptr, wr_ptr;
    logic [1:0]                 fifo_count;

    logic                       cmd_fire;
    logic                       addr_bad;
    logic                       fifo_valid;
    logic                       pop;
    logic                       push;
    logic [1:0]                 occupancy;
    logic [1:0]                 occupancy_after_pop;
    logic                       issue;
    logic                       issue_last;

    assign cmd_fire            = (state_q == S_IDLE) && bus.cmd_valid;
    assign addr_bad            = {1'b0, bus.cmd_addr} >= DEPTH_EXT;
    assign fifo_valid          = (fifo_count != 2'd0);
    assign pop                 = fifo_valid && bus.out_ready;
    // The read issued last cycle lands in the FIFO at the end of this cycle.
    assign push                = inflight_q;
    // Occupancy counts buffered words plus the read still in the memory pipe;
    // keeping it below 2 after this cycle's pop guarantees the FIFO never fills past 2.
    assign occupancy           = fifo_count + {1'b0, inflight_q};
    assign occupancy_after_pop = occupancy - {1'b0, pop};
    assign issue               = (state_q == S_ISSUE) && (occupancy_after_pop < 2'd2);
    assign issue_last          = issue && (remaining_q == LEN_WIDTH'(1));

    // Next-state, address and remaining-count logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        drain_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_addr;
                    remaining_d = bus.cmd_len;
                    if (!addr_bad && (bus.cmd_len != '0)) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (issue_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && !fifo_valid) begin
                    drain_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, in-flight tracking and null/reject completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            done_q          <= cmd_fire && (addr_bad || (bus.cmd_len == '0));
            err_q           <= cmd_fire && addr_bad;
        end
    end

    // FIFO pointers and count; push and pop in the same cycle both take effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage; contents are only visible through the count-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_rd_data;
            fifo_last[wr_ptr] <= inflight_last_q;
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = issue ? addr_q : '0;
    assign bus.out_valid   = fifo_valid;
    assign bus.out_data    = fifo_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_last    = fifo_valid && fifo_last[rd_ptr];

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q || drain_done;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
